pwm_spi_expander: RTL and testbench

//  Parametrised SPI-slave PWM IO expander. An external host writes per-channel

---
 rtl/pwm_spi_expander.sv | 230 +++++++++++++++++++++++
 tb/tb_pwm_spi_expander.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_spi_expander.sv
// SPI-slave (mode 0) PWM IO expander: per-channel duty/prescale/control registers
// written over an oversampled SPI link, NUM_CH shadowed glitch-free PWM outputs.
module pwm_spi_expander #(
  parameter int unsigned NUM_CH        = 8,
  parameter int unsigned PWM_BITS      = 8,
  parameter int unsigned PRESCALE_BITS = 8,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic              MainCLK,
  input  logic              RST,
  input  logic              CS,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  output logic [NUM_CH-1:0] PWM_OUT,
  output logic [3:0]        OnBoardLEDS
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic sclk_prev_q, cs_prev_q;
  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_t      state_q, state_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [6:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic [6:0]  addr_q, addr_d;
  logic        rw_q, rw_d;
  logic        wr_en, abort;
  logic [6:0]  cmd_addr;
  logic [7:0]  rd_data, wr_data;

  logic                     en_q, inv_q, err_q, hb_q;
  logic [7:0]               prescale_q;
  logic [PWM_BITS-1:0]      shadow_q [NUM_CH];
  logic [PWM_BITS-1:0]      active_q [NUM_CH];
  logic [PRESCALE_BITS-1:0] presc_cnt_q, presc_lim_q, presc_load;
  logic [PWM_BITS-1:0]      cnt_q;
  logic                     tick, wrap;
  logic [NUM_CH-1:0]        pwm_q;

  // CS chain idles high so the CS-active LED reads 0 straight out of reset.
  always_ff @(posedge MainCLK) begin
    if (RST) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  assign cmd_addr = {rx_q[5:0], mosi_s};
  assign wr_data  = {rx_q, mosi_s};

  always_comb begin
    rd_data = '0;
    case (cmd_addr)
      7'h00:   rd_data = {6'b0, inv_q, en_q};
      7'h01:   rd_data = prescale_q;
      7'h02:   rd_data = 8'hA5;
      7'h03:   rd_data = 8'(NUM_CH);
      default: begin
        for (int unsigned n = 0; n < NUM_CH; n++)
          if (cmd_addr == 7'(16 + n)) rd_data = 8'(shadow_q[n]);
      end
    endcase
  end

  // The falling edge right after the 8th rising edge precedes the host's first
  // data sample, so TX only shifts once a data bit has been clocked in.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    wr_en    = 1'b0;
    abort    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          state_d  = S_CMD;
          bitcnt_d = '0;
        end
      end
      S_CMD: begin
        if (cs_rise) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end else if (sclk_rise) begin
          rx_d     = {rx_q[5:0], mosi_s};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = S_DATA;
            rw_d    = rx_q[6];
            addr_d  = cmd_addr;
            tx_d    = rx_q[6] ? rd_data : '0;
          end
        end
      end
      S_DATA: begin
        if (cs_rise) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end else if (sclk_rise) begin
          rx_d     = {rx_q[5:0], mosi_s};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = S_DONE;
            wr_en   = ~rw_q;
          end
        end else if (sclk_fall && bitcnt_q != 3'd0) begin
          tx_d = {tx_q[6:0], 1'b0};
        end
      end
      S_DONE: begin
        if (cs_rise) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge MainCLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      rx_q     <= '0;
      tx_q     <= '0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
    end
  end

  always_ff @(posedge MainCLK) begin
    if (RST) begin
      en_q       <= 1'b0;
      inv_q      <= 1'b0;
      err_q      <= 1'b0;
      prescale_q <= '0;
      for (int unsigned n = 0; n < NUM_CH; n++) shadow_q[n] <= '0;
    end else begin
      if (abort) err_q <= 1'b1;
      if (wr_en) begin
        case (addr_q)
          7'h00: begin
            en_q  <= wr_data[0];
            inv_q <= wr_data[1];
            if (wr_data[7]) err_q <= 1'b0;
          end
          7'h01:   prescale_q <= wr_data;
          default: begin
            for (int unsigned n = 0; n < NUM_CH; n++)
              if (addr_q == 7'(16 + n)) shadow_q[n] <= wr_data[PWM_BITS-1:0];
          end
        endcase
      end
    end
  end

  assign presc_load = PRESCALE_BITS'(prescale_q);
  assign tick       = (presc_cnt_q == presc_lim_q);
  assign wrap       = tick && (cnt_q == '1);

  // Prescale limit is only re-latched at a tick so a PRESCALE write never
  // truncates the count in progress; while disabled active duty tracks shadow.
  always_ff @(posedge MainCLK) begin
    if (RST) begin
      presc_cnt_q <= '0;
      presc_lim_q <= '0;
      cnt_q       <= '0;
      hb_q        <= 1'b0;
      for (int unsigned n = 0; n < NUM_CH; n++) active_q[n] <= '0;
    end else if (!en_q) begin
      presc_cnt_q <= '0;
      presc_lim_q <= presc_load;
      cnt_q       <= '0;
      active_q    <= shadow_q;
    end else if (tick) begin
      presc_cnt_q <= '0;
      presc_lim_q <= presc_load;
      cnt_q       <= cnt_q + PWM_BITS'(1);
      if (wrap) begin
        hb_q     <= ~hb_q;
        active_q <= shadow_q;
      end
    end else begin
      presc_cnt_q <= presc_cnt_q + PRESCALE_BITS'(1);
    end
  end

  always_ff @(posedge MainCLK) begin
    if (RST) begin
      pwm_q <= '0;
    end else begin
      for (int unsigned n = 0; n < NUM_CH; n++)
        pwm_q[n] <= (en_q & (cnt_q < active_q[n])) ^ (inv_q & en_q);
    end
  end

  assign PWM_OUT     = pwm_q;
  assign MISO        = (state_q == S_DATA) & tx_q[7];
  assign OnBoardLEDS = {~cs_s, hb_q, err_q, en_q};

endmodule

// File: tb/tb_pwm_spi_expander.sv
// Directed bench for pwm_spi_expander: table of SPI register transactions plus
// hand sequences for PWM duty, inversion, shadowing, abort and reset corners.
module tb_pwm_spi_expander;

  localparam int NUM_CH = 8;
  localparam int HALF   = 8;

  logic              clk = 1'b0;
  logic              rst, cs, sclk, mosi;
  logic              miso;
  logic [NUM_CH-1:0] pwm;
  logic [3:0]        leds;

  always #5 clk = ~clk;

  pwm_spi_expander #(
    .NUM_CH(NUM_CH),
    .PWM_BITS(8),
    .PRESCALE_BITS(8),
    .SYNC_STAGES(2)
  ) dut (
    .MainCLK(clk),
    .RST(rst),
    .CS(cs),
    .SCLK(sclk),
    .MOSI(mosi),
    .MISO(miso),
    .PWM_OUT(pwm),
    .OnBoardLEDS(leds)
  );

  typedef struct {
    string      name;
    logic [7:0] cmd;
    logic [7:0] data;
    int         nbits;
    bit         chk;
    logic [7:0] exp_rd;
    logic [3:0] exp_led;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   hi_cnt[NUM_CH];

  function automatic vec_t mk(input string nm, input logic [7:0] c, input logic [7:0] d,
                              input int nb, input bit ck, input logic [7:0] er,
                              input logic [3:0] el);
    vec_t v;
    v.name = nm; v.cmd = c; v.data = d; v.nbits = nb;
    v.chk = ck; v.exp_rd = er; v.exp_led = el;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_frame(input logic [7:0] cmd, input logic [7:0] data, input int nbits,
                           output logic [7:0] rd, output logic miso_cmd);
    logic [15:0] word;
    word     = {cmd, data};
    rd       = '0;
    miso_cmd = 1'b0;
    @(negedge clk);
    cs = 1'b0;
    wait_cyc(8);
    for (int i = 0; i < nbits; i++) begin
      mosi = word[15-i];
      wait_cyc(HALF);
      if (i >= 8) rd = {rd[6:0], miso};
      else        miso_cmd = miso_cmd | miso;
      sclk = 1'b1;
      wait_cyc(HALF);
      sclk = 1'b0;
    end
    wait_cyc(HALF);
    cs = 1'b1;
    wait_cyc(8);
  endtask

  task automatic spi_write(input logic [7:0] addr, input logic [7:0] data);
    logic [7:0] rd;
    logic       mc;
    spi_frame({1'b0, addr[6:0]}, data, 16, rd, mc);
  endtask

  task automatic window(input int len);
    for (int n = 0; n < NUM_CH; n++) hi_cnt[n] = 0;
    repeat (len) begin
      @(negedge clk);
      for (int n = 0; n < NUM_CH; n++) if (pwm[n]) hi_cnt[n]++;
    end
  endtask

  task automatic wait_led2(input int maxc, output int waited, output bit ok);
    logic p;
    p      = leds[2];
    ok     = 1'b0;
    waited = 0;
    while (waited < maxc) begin
      @(negedge clk);
      waited++;
      if (leds[2] !== p) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic measure_high(input int maxc, output int len);
    int w;
    w   = 0;
    len = -1;
    while (pwm[0] !== 1'b1 && w < maxc) begin
      @(negedge clk);
      w++;
    end
    if (w < maxc) begin
      len = 0;
      while (pwm[0] === 1'b1 && len < maxc) begin
        @(negedge clk);
        len++;
      end
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic       mc;
    int         w1, w2, l1, l2;
    bit         ok1, ok2;

    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(1);
    check("reset pwm", pwm, 0);
    check("reset miso", miso, 0);
    check("reset leds", leds, 0);

    tbl.push_back(mk("rd_id",        8'h82, 8'h00, 16, 1'b1, 8'hA5, 4'b0000));
    tbl.push_back(mk("rd_numch",     8'h83, 8'h00, 16, 1'b1, 8'h08, 4'b0000));
    tbl.push_back(mk("wr_unmapped",  8'h7F, 8'h55, 16, 1'b0, 8'h00, 4'b0000));
    tbl.push_back(mk("rd_unmapped",  8'hFF, 8'h00, 16, 1'b1, 8'h00, 4'b0000));
    tbl.push_back(mk("wr_id_ro",     8'h02, 8'h12, 16, 1'b0, 8'h00, 4'b0000));
    tbl.push_back(mk("rd_id_again",  8'h82, 8'h00, 16, 1'b1, 8'hA5, 4'b0000));
    tbl.push_back(mk("wr_duty7",     8'h17, 8'h3C, 16, 1'b0, 8'h00, 4'b0000));
    tbl.push_back(mk("rd_duty7",     8'h97, 8'h00, 16, 1'b1, 8'h3C, 4'b0000));
    tbl.push_back(mk("rd_duty8_oob", 8'h98, 8'h00, 16, 1'b1, 8'h00, 4'b0000));
    tbl.push_back(mk("wr_presc",     8'h01, 8'h05, 16, 1'b0, 8'h00, 4'b0000));
    tbl.push_back(mk("rd_presc",     8'h81, 8'h00, 16, 1'b1, 8'h05, 4'b0000));
    tbl.push_back(mk("wr_ctrl_en_inv", 8'h00, 8'h03, 16, 1'b0, 8'h00, 4'b0001));
    tbl.push_back(mk("rd_ctrl",      8'h80, 8'h00, 16, 1'b1, 8'h03, 4'b0001));
    tbl.push_back(mk("wr_ctrl_off",  8'h00, 8'h80, 16, 1'b0, 8'h00, 4'b0000));
    tbl.push_back(mk("rd_ctrl_b7",   8'h80, 8'h00, 16, 1'b1, 8'h00, 4'b0000));
    tbl.push_back(mk("wr_duty1",     8'h11, 8'h22, 16, 1'b0, 8'h00, 4'b0000));
    tbl.push_back(mk("abort_duty1",  8'h11, 8'h77, 12, 1'b0, 8'h00, 4'b0010));
    tbl.push_back(mk("rd_duty1",     8'h91, 8'h00, 16, 1'b1, 8'h22, 4'b0010));
    tbl.push_back(mk("wr_ctrl_clr",  8'h00, 8'h81, 16, 1'b0, 8'h00, 4'b0001));
    tbl.push_back(mk("wr_ctrl_0",    8'h00, 8'h00, 16, 1'b0, 8'h00, 4'b0000));
    tbl.push_back(mk("wr_presc0",    8'h01, 8'h00, 16, 1'b0, 8'h00, 4'b0000));
    tbl.push_back(mk("rd_presc0",    8'h81, 8'h00, 16, 1'b1, 8'h00, 4'b0000));
    tbl.push_back(mk("rd_0x40",      8'hC0, 8'h00, 16, 1'b1, 8'h00, 4'b0000));

    foreach (tbl[i]) begin
      spi_frame(tbl[i].cmd, tbl[i].data, tbl[i].nbits, rd, mc);
      if (tbl[i].chk) check(tbl[i].name, rd, tbl[i].exp_rd);
      check({tbl[i].name, " leds"}, leds & 4'b1011, tbl[i].exp_led);
      check({tbl[i].name, " miso_cmd"}, mc, 0);
    end

    spi_write(8'h10, 8'h40);
    spi_write(8'h12, 8'h00);
    spi_write(8'h13, 8'hFF);
    spi_write(8'h00, 8'h01);
    wait_cyc(4);
    window(256);
    check("duty ch0 0x40", hi_cnt[0], 64);
    check("duty ch1 0x22", hi_cnt[1], 34);
    check("duty ch2 0x00", hi_cnt[2], 0);
    check("duty ch3 0xFF", hi_cnt[3], 255);
    check("duty ch4 0x00", hi_cnt[4], 0);
    check("duty ch7 0x3C", hi_cnt[7], 60);

    wait_led2(600, w1, ok1);
    check("heartbeat seen", ok1, 1);
    wait_led2(600, w2, ok2);
    check("heartbeat spacing", w2, 256);

    spi_write(8'h00, 8'h03);
    wait_cyc(4);
    window(256);
    check("inv ch0", hi_cnt[0], 192);
    check("inv ch2", hi_cnt[2], 256);
    check("inv ch3", hi_cnt[3], 1);

    spi_write(8'h00, 8'h01);
    spi_write(8'h01, 8'h0F);
    wait_led2(10000, w1, ok1);
    check("wrap before shadow test", ok1, 1);
    fork
      spi_write(8'h10, 8'hC0);
      begin
        measure_high(5000, l1);
        measure_high(5000, l2);
      end
    join
    check("shadow current period", l1, 1024);
    check("shadow next period", l2, 3072);

    spi_write(8'h00, 8'h00);
    wait_cyc(3);
    check("disabled pwm", pwm, 0);
    check("disabled leds", leds & 4'b1011, 0);

    cs = 1'b0;
    wait_cyc(8);
    check("cs active led", leds[3], 1);
    cs = 1'b1;
    wait_cyc(8);
    check("cs-only abort err", leds[1], 1);

    cs = 1'b0;
    wait_cyc(8);
    for (int i = 0; i < 5; i++) begin
      mosi = 1'b1;
      wait_cyc(HALF);
      sclk = 1'b1;
      wait_cyc(HALF);
      sclk = 1'b0;
    end
    rst = 1'b1;
    wait_cyc(2);
    cs = 1'b1; mosi = 1'b0;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(8);
    check("midframe reset leds", leds, 0);
    spi_frame(8'h82, 8'h00, 16, rd, mc);
    check("post-reset rd_id", rd, 8'hA5);
    spi_frame(8'h90, 8'h00, 16, rd, mc);
    check("post-reset duty0", rd, 8'h00);
    check("post-reset pwm", pwm, 0);
    check("post-reset leds", leds, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
